// File: rtl/noc_node_vc.sv
// NoC endpoint: buffers outbound packets and serialises them as header + payload
// bytes toward the router; reassembles inbound bytes into a packet queue drained
// by a valid/ready handshake.
// Handshake (pkt_out): a packet transfers on a clock edge where pkt_out_avail and
// pkt_out_ready are both 1; pkt_out is stable while pkt_out_avail is high and not popped.
module noc_node_vc #(
    parameter int NODEID     = 0,
    parameter int DATA_BYTES = 3,
    parameter int TXQ_DEPTH  = 4,
    parameter int RXQ_DEPTH  = 2,
    localparam int PKT_W     = 8 + 8 * DATA_BYTES,
    localparam int CW        = $clog2(TXQ_DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_b,
    input  logic [PKT_W-1:0] pkt_in,
    input  logic             pkt_in_avail,
    output logic             cQ_full,
    output logic [CW-1:0]    txq_count,
    output logic [7:0]       drop_count,
    output logic [PKT_W-1:0] pkt_out,
    output logic             pkt_out_avail,
    input  logic             pkt_out_ready,
    input  logic             free_outbound,
    output logic             put_outbound,
    output logic [7:0]       payload_outbound,
    output logic             free_inbound,
    input  logic             put_inbound,
    input  logic [7:0]       payload_inbound,
    output logic             misroute_err
);
    localparam int DW  = 8 * DATA_BYTES;
    localparam int TPW = $clog2(TXQ_DEPTH);
    localparam int RPW = (RXQ_DEPTH > 1) ? $clog2(RXQ_DEPTH) : 1;
    localparam int RCW = $clog2(RXQ_DEPTH + 1);
    localparam int IW  = $clog2(DATA_BYTES + 1);

    typedef enum logic {T_IDLE, T_SEND} tx_state_t;

    // ---------------- TX FIFO ----------------
    logic [PKT_W-1:0] txq_mem [TXQ_DEPTH];
    logic [TPW-1:0]   tx_wr, tx_rd;
    logic [CW-1:0]    tx_cnt;
    logic             tx_push, tx_pop, tx_empty;
    logic [PKT_W-1:0] tx_head;

    assign cQ_full   = (tx_cnt == CW'(TXQ_DEPTH));
    assign tx_empty  = (tx_cnt == '0);
    assign txq_count = tx_cnt;
    // Full is a registered condition, so a pop in the same cycle never frees a slot early.
    assign tx_push   = pkt_in_avail && !cQ_full;
    assign tx_head   = txq_mem[tx_rd];

    // TX storage write (no reset needed; validity is tracked by tx_cnt)
    always_ff @(posedge clock) begin
        if (tx_push) txq_mem[tx_wr] <= pkt_in;
    end

    // TX pointers, occupancy and saturating drop counter; pointers wrap at any depth
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            tx_wr      <= '0;
            tx_rd      <= '0;
            tx_cnt     <= '0;
            drop_count <= '0;
        end else begin
            if (tx_push) tx_wr <= (tx_wr == TPW'(TXQ_DEPTH - 1)) ? '0 : tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= (tx_rd == TPW'(TXQ_DEPTH - 1)) ? '0 : tx_rd + 1'b1;
            if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
            else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
            if (pkt_in_avail && cQ_full && drop_count != 8'hFF) drop_count <= drop_count + 1'b1;
        end
    end

    // ---------------- TX serialiser ----------------
    tx_state_t      tx_state, tx_next;
    logic [DW-1:0]  tx_sh;
    logic [IW-1:0]  tx_idx;
    logic           tx_gap;   // forces one idle cycle after every packet

    // TX next state and byte outputs; the header goes out in the cycle the head is popped
    always_comb begin
        tx_next          = tx_state;
        tx_pop           = 1'b0;
        put_outbound     = 1'b0;
        payload_outbound = '0;
        case (tx_state)
            T_IDLE: begin
                if (free_outbound && !tx_empty && !tx_gap) begin
                    put_outbound     = 1'b1;
                    payload_outbound = tx_head[PKT_W-1 -: 8];
                    tx_pop           = 1'b1;
                    tx_next          = T_SEND;
                end
            end
            T_SEND: begin
                put_outbound     = 1'b1;
                payload_outbound = tx_sh[DW-1 -: 8];
                if (tx_idx == IW'(DATA_BYTES)) tx_next = T_IDLE;
            end
            default: tx_next = T_IDLE;
        endcase
    end

    // TX state register, payload shift register (MSB byte first) and byte index
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            tx_state <= T_IDLE;
            tx_sh    <= '0;
            tx_idx   <= '0;
            tx_gap   <= 1'b0;
        end else begin
            tx_state <= tx_next;
            tx_gap   <= (tx_state == T_SEND) && (tx_next == T_IDLE);
            if (tx_pop) begin
                tx_sh  <= tx_head[DW-1:0];
                tx_idx <= IW'(1);
            end else if (tx_state == T_SEND) begin
                tx_sh  <= tx_sh << 8;
                tx_idx <= tx_idx + 1'b1;
            end
        end
    end

    // ---------------- RX deserialiser + queue ----------------
    logic [IW-1:0]    rcnt;
    logic [PKT_W-9:0] rx_asm;   // bytes received so far, newest in the low byte
    logic [PKT_W-1:0] rxq_mem [RXQ_DEPTH];
    logic [RPW-1:0]   rx_wr, rx_rd;
    logic [RCW-1:0]   rx_cnt;
    logic             hdr_take, rx_push, rx_pop;

    assign free_inbound  = (rcnt == '0) && (rx_cnt < RCW'(RXQ_DEPTH));
    assign hdr_take      = put_inbound && free_inbound;
    assign rx_push       = put_inbound && (rcnt == IW'(DATA_BYTES));
    assign pkt_out_avail = (rx_cnt != '0);
    assign rx_pop        = pkt_out_avail && pkt_out_ready;
    assign pkt_out       = pkt_out_avail ? rxq_mem[rx_rd] : '0;

    // RX storage write of the completed packet
    always_ff @(posedge clock) begin
        if (rx_push) rxq_mem[rx_wr] <= {rx_asm, payload_inbound};
    end

    // RX byte counter, assembly register, queue pointers and sticky misroute flag
    always_ff @(posedge clock or negedge reset_b) begin
        if (!reset_b) begin
            rcnt         <= '0;
            rx_asm       <= '0;
            rx_wr        <= '0;
            rx_rd        <= '0;
            rx_cnt       <= '0;
            misroute_err <= 1'b0;
        end else begin
            if (hdr_take || (put_inbound && rcnt != '0))
                rx_asm <= (rx_asm << 8) | (PKT_W-8)'(payload_inbound);
            if (hdr_take) begin
                rcnt <= IW'(1);
                if (payload_inbound[3:0] != 4'(NODEID)) misroute_err <= 1'b1;
            end else if (rx_push) begin
                rcnt <= '0;
            end else if (put_inbound && rcnt != '0) begin
                rcnt <= rcnt + 1'b1;
            end
            if (rx_push) rx_wr <= (rx_wr == RPW'(RXQ_DEPTH - 1)) ? '0 : rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= (rx_rd == RPW'(RXQ_DEPTH - 1)) ? '0 : rx_rd + 1'b1;
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
            else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_noc_node_vc.sv
// Testbench for noc_node_vc (NODEID=1, DATA_BYTES=3, TXQ_DEPTH=4, RXQ_DEPTH=2).
module tb_noc_node_vc;
    logic        clock = 1'b0;
    logic        reset_b = 1'b0;
    logic [31:0] pkt_in = '0;
    logic        pkt_in_avail = 1'b0;
    logic        cQ_full;
    logic [2:0]  txq_count;
    logic [7:0]  drop_count;
    logic [31:0] pkt_out;
    logic        pkt_out_avail;
    logic        pkt_out_ready = 1'b0;
    logic        free_outbound = 1'b0;
    logic        put_outbound;
    logic [7:0]  payload_outbound;
    logic        free_inbound;
    logic        put_inbound = 1'b0;
    logic [7:0]  payload_inbound = '0;
    logic        misroute_err;

    int checks = 0;
    int failures = 0;
    logic [31:0] tx_q[$];   // expected outbound bytes
    logic [31:0] rx_q[$];   // expected delivered packets
    int gap_q[$];           // idle cycles seen before each outbound packet
    int run = 0;
    int idle = 0;

    noc_node_vc #(.NODEID(1), .DATA_BYTES(3), .TXQ_DEPTH(4), .RXQ_DEPTH(2)) dut (
        .clock(clock), .reset_b(reset_b), .pkt_in(pkt_in), .pkt_in_avail(pkt_in_avail),
        .cQ_full(cQ_full), .txq_count(txq_count), .drop_count(drop_count),
        .pkt_out(pkt_out), .pkt_out_avail(pkt_out_avail), .pkt_out_ready(pkt_out_ready),
        .free_outbound(free_outbound), .put_outbound(put_outbound),
        .payload_outbound(payload_outbound), .free_inbound(free_inbound),
        .put_inbound(put_inbound), .payload_inbound(payload_inbound),
        .misroute_err(misroute_err)
    );

    // clock / watchdog
    always #5 clock = ~clock;
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_full"}, 32'(cQ_full), 0);
        check({tag, "_count"}, 32'(txq_count), 0);
        check({tag, "_drop"}, 32'(drop_count), 0);
        check({tag, "_pkt_out"}, pkt_out, 0);
        check({tag, "_avail"}, 32'(pkt_out_avail), 0);
        check({tag, "_put"}, 32'(put_outbound), 0);
        check({tag, "_payload"}, 32'(payload_outbound), 0);
        check({tag, "_free_in"}, 32'(free_inbound), 1);
        check({tag, "_misroute"}, 32'(misroute_err), 0);
    endtask

    task automatic push_tx_bytes(input logic [31:0] p);
        for (int i = 0; i < 4; i++) tx_q.push_back(32'(p[31-8*i -: 8]));
    endtask

    task automatic write_pkt(input logic [31:0] p);
        pkt_in = p;
        pkt_in_avail = 1'b1;
        tick();
        pkt_in_avail = 1'b0;
    endtask

    task automatic wait_tx_drain(input string tag);
        int n = 0;
        while ((tx_q.size() != 0 || put_outbound) && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_tx_drain"}, 32'(tx_q.size()), 0);
        tick();
    endtask

    task automatic wait_rx_drain(input string tag);
        int n = 0;
        while (pkt_out_avail && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_rx_drain"}, 32'(rx_q.size()), 0);
    endtask

    // drives one inbound packet; gap_at inserts a put_inbound=0 cycle before that byte
    task automatic send_rx(input logic [31:0] p, input int gap_at);
        int n = 0;
        while (!free_inbound && n < 200) begin
            tick();
            n++;
        end
        check("rx_free_wait", 32'(free_inbound), 1);
        for (int i = 0; i < 4; i++) begin
            if (i == gap_at) begin
                put_inbound = 1'b0;
                tick();
            end
            put_inbound = 1'b1;
            payload_inbound = p[31-8*i -: 8];
            tick();
        end
        put_inbound = 1'b0;
        payload_inbound = '0;
    endtask

    // scoreboard: outbound byte stream and packet length/gap tracking
    always @(negedge clock) begin
        if (!reset_b) begin
            run = 0;
            idle = 0;
        end else if (put_outbound) begin
            if (run == 0) gap_q.push_back(idle);
            run++;
            idle = 0;
            if (tx_q.size() == 0) check("tx_extra_byte", 32'(tx_q.size()), 1);
            else check("tx_byte", 32'(payload_outbound), tx_q.pop_front());
        end else begin
            if (run != 0) check("tx_pkt_len", 32'(run), 4);
            run = 0;
            idle++;
            check("tx_idle_payload", 32'(payload_outbound), 0);
        end
    end

    // scoreboard: delivered packets
    always @(negedge clock) begin
        if (reset_b && pkt_out_avail && pkt_out_ready) begin
            if (rx_q.size() == 0) check("rx_extra_pkt", 32'(rx_q.size()), 1);
            else check("rx_pkt", pkt_out, rx_q.pop_front());
        end
    end

    initial begin
        // reset and idle
        #12;
        check_reset_outputs("in_reset");
        tick();
        reset_b = 1'b1;
        repeat (3) tick();
        check_reset_outputs("post_reset");

        // single packet serialisation
        free_outbound = 1'b1;
        push_tx_bytes(32'h12AABBCC);
        write_pkt(32'h12AABBCC);
        wait_tx_drain("single");

        // fill with router blocked, then saturate the drop counter
        free_outbound = 1'b0;
        for (int i = 0; i < 6; i++) begin
            logic [31:0] p;
            p = {8'h34, 8'(i), 8'h5A, 8'(240 + i)};
            if (i < 4) push_tx_bytes(p);
            pkt_in = p;
            pkt_in_avail = 1'b1;
            tick();
        end
        check("fill_full", 32'(cQ_full), 1);
        check("fill_count", 32'(txq_count), 4);
        check("fill_drop", 32'(drop_count), 2);
        repeat (260) tick();
        pkt_in_avail = 1'b0;
        check("drop_saturate", 32'(drop_count), 255);
        check("sat_count", 32'(txq_count), 4);
        gap_q.delete();
        free_outbound = 1'b1;
        wait_tx_drain("release");
        check("release_pkts", 32'(gap_q.size()), 4);
        for (int k = 1; k < gap_q.size(); k++) check("release_gap", 32'(gap_q[k]), 1);
        check("release_empty", 32'(txq_count), 0);
        check("release_not_full", 32'(cQ_full), 0);

        // inbound packets with ready held low
        pkt_out_ready = 1'b0;
        rx_q.push_back(32'h21112233);
        send_rx(32'h21112233, -1);
        check("rx1_avail", 32'(pkt_out_avail), 1);
        check("rx1_pkt_out", pkt_out, 32'h21112233);
        rx_q.push_back(32'h41314455);
        send_rx(32'h41314455, 2);
        check("rxq_full_free", 32'(free_inbound), 0);
        put_inbound = 1'b1;
        payload_inbound = 8'h19;
        tick();
        put_inbound = 1'b0;
        payload_inbound = '0;
        check("ignored_hdr_misroute", 32'(misroute_err), 0);
        check("ignored_hdr_head", pkt_out, 32'h21112233);
        pkt_out_ready = 1'b1;
        wait_rx_drain("rx_pair");
        check("rx_free_after_drain", 32'(free_inbound), 1);

        // misrouted header is flagged and still delivered
        rx_q.push_back(32'h35010203);
        send_rx(32'h35010203, -1);
        check("misroute_set", 32'(misroute_err), 1);
        wait_rx_drain("misroute");
        check("misroute_sticky", 32'(misroute_err), 1);

        // reset mid-packet in both directions
        pkt_out_ready = 1'b0;
        put_inbound = 1'b1;
        payload_inbound = 8'h21;
        tick();
        payload_inbound = 8'hDE;
        tick();
        put_inbound = 1'b0;
        payload_inbound = '0;
        push_tx_bytes(32'h12445566);
        write_pkt(32'h12445566);
        begin
            int n = 0;
            while (tx_q.size() > 2 && n < 50) begin
                tick();
                n++;
            end
        end
        reset_b = 1'b0;
        tx_q.delete();
        free_outbound = 1'b0;
        #2;
        check_reset_outputs("mid_reset");
        tick();
        reset_b = 1'b1;
        tick();
        send_rx(32'h21A1B2C3, -1);
        check("after_reset_pkt", pkt_out, 32'h21A1B2C3);
        check("after_reset_misroute", 32'(misroute_err), 0);
        rx_q.push_back(32'h21A1B2C3);
        pkt_out_ready = 1'b1;
        wait_rx_drain("after_reset");
        check("after_reset_avail", 32'(pkt_out_avail), 0);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
